// File: rtl/e1_pkg.sv
// Shared types and default thresholds for the E1 receive
// clock-recovery supervisor.
package e1_pkg;

    typedef enum logic [1:0] {
        ST_RESET_REC = 2'd0,
        ST_ACQUIRE   = 2'd1,
        ST_LOCKED    = 2'd2,
        ST_LOS       = 2'd3
    } e1_state_e;

    localparam int DEF_LOS_ZEROS     = 32;
    localparam int DEF_AIS_WINDOW    = 512;
    localparam int DEF_AIS_MAX_ZEROS = 2;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/e1_rx_recovery_ctrl_if.sv
// Bit-stream, status and counter signals between the LIU/recovery
// front end and the recovery supervisor.
interface e1_rx_recovery_ctrl_if;

    logic        pls_stb;
    logic        bit_hi;
    logic        bit_lo;
    logic        bit_stb;
    logic        cerr_clr;
    logic        rec_rst;
    logic        lock;
    logic        los;
    logic        ais;
    logic [1:0]  state;
    logic [15:0] cerr_cnt;

    modport master (
        output pls_stb, bit_hi, bit_lo, bit_stb, cerr_clr,
        input  rec_rst, lock, los, ais, state, cerr_cnt
    );

    modport slave (
        input  pls_stb, bit_hi, bit_lo, bit_stb, cerr_clr,
        output rec_rst, lock, los, ais, state, cerr_cnt
    );

endinterface

// File: rtl/e1_rx_ais_detect.sv
// Windowed all-ones (AIS) detector: counts zeros over a fixed
// number of recovered bits while enabled.
module e1_rx_ais_detect
    import e1_pkg::*;
#(
    parameter int AIS_WINDOW    = DEF_AIS_WINDOW,
    parameter int AIS_MAX_ZEROS = DEF_AIS_MAX_ZEROS
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic bit_stb_i,
    input  logic zero_i,
    output logic ais_o
);

    localparam int WW = $clog2(AIS_WINDOW);
    localparam int ZW = $clog2(AIS_MAX_ZEROS + 2);
    localparam logic [WW-1:0] WIN_LAST = WW'(AIS_WINDOW - 1);
    localparam logic [ZW-1:0] Z_SAT    = ZW'(AIS_MAX_ZEROS + 1);
    localparam logic [ZW-1:0] Z_MAX    = ZW'(AIS_MAX_ZEROS);

    logic [WW-1:0] win_q;
    logic [ZW-1:0] zcnt_q;
    logic [ZW-1:0] zcnt_d;
    logic          ais_q;

    // zero count including the current bit, so the last bit counts
    always_comb begin
        zcnt_d = zcnt_q;
        if (zero_i && zcnt_q != Z_SAT) begin
            zcnt_d = zcnt_q + ZW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !en_i) begin
            win_q  <= '0;
            zcnt_q <= '0;
            ais_q  <= 1'b0;
        end else if (bit_stb_i) begin
            if (win_q == WIN_LAST) begin
                ais_q  <= (zcnt_d <= Z_MAX);
                win_q  <= '0;
                zcnt_q <= '0;
            end else begin
                win_q  <= win_q + WW'(1);
                zcnt_q <= zcnt_d;
            end
        end
    end

    assign ais_o = ais_q;

endmodule

// File: rtl/e1_rx_recovery_ctrl.sv
// E1 receive clock-recovery supervisor: reset sequencing,
// acquisition, lock, LOS/AIS monitoring and code-error counting.
module e1_rx_recovery_ctrl
    import e1_pkg::*;
#(
    parameter int RST_CYCLES    = 4,
    parameter int ACQ_PULSES    = 16,
    parameter int LOS_ZEROS     = DEF_LOS_ZEROS,
    parameter int AIS_WINDOW    = DEF_AIS_WINDOW,
    parameter int AIS_MAX_ZEROS = DEF_AIS_MAX_ZEROS,
    parameter int WDOG_CYCLES   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    e1_rx_recovery_ctrl_if.slave  bus
);

    localparam logic [3:0] RST_LAST = 4'(RST_CYCLES - 1);
    localparam logic [7:0] ACQ_N    = 8'(ACQ_PULSES);
    localparam logic [7:0] LOS_N    = 8'(LOS_ZEROS);
    localparam logic [7:0] WDOG_N   = 8'(WDOG_CYCLES);

    e1_state_e   state_q, state_d;
    logic [3:0]  rcnt_q, rcnt_d;
    logic [7:0]  acq_q, acq_d;
    logic [7:0]  zrun_q, zrun_d, zrun_nx;
    logic [7:0]  wdog_q, wdog_d;
    logic [15:0] cerr_q, cerr_d;
    logic        rec_rst_q, lock_q, los_q;
    logic        mark, zero, cerr, ais_en;

    assign mark = bus.bit_stb & (bus.bit_hi | bus.bit_lo);
    assign zero = bus.bit_stb & ~bus.bit_hi & ~bus.bit_lo;
    assign cerr = bus.bit_stb & bus.bit_hi & bus.bit_lo;

    always_comb begin
        zrun_nx = zrun_q;
        unique case (1'b1)
            mark:    zrun_nx = '0;
            zero:    zrun_nx = sat_inc8(zrun_q);
            default: zrun_nx = zrun_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        acq_d   = acq_q;
        zrun_d  = zrun_q;
        wdog_d  = wdog_q;
        unique case (state_q)
            ST_RESET_REC: begin
                rcnt_d = rcnt_q + 4'd1;
                if (rcnt_q == RST_LAST) state_d = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
                zrun_d = zrun_nx;
                if (mark) acq_d = acq_q + 8'd1;
                if (zero && zrun_nx == LOS_N) begin
                    state_d = ST_LOS;
                end else if (mark && acq_d == ACQ_N) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                zrun_d = zrun_nx;
                wdog_d = bus.bit_stb ? 8'd0 : wdog_q + 8'd1;
                if (zero && zrun_nx == LOS_N) begin
                    state_d = ST_LOS;
                end else if (wdog_d == WDOG_N) begin
                    state_d = ST_RESET_REC;
                end
            end
            ST_LOS: begin
                if (bus.pls_stb) state_d = ST_RESET_REC;
            end
            default: state_d = ST_RESET_REC;
        endcase
        // every state starts with fresh counters
        if (state_d != state_q) begin
            rcnt_d = '0;
            acq_d  = '0;
            zrun_d = '0;
            wdog_d = '0;
        end
    end

    always_comb begin
        cerr_d = cerr_q;
        if (bus.cerr_clr) begin
            cerr_d = '0;
        end else if (cerr && state_q != ST_RESET_REC
                     && cerr_q != 16'hFFFF) begin
            cerr_d = cerr_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RESET_REC;
            rcnt_q    <= '0;
            acq_q     <= '0;
            zrun_q    <= '0;
            wdog_q    <= '0;
            cerr_q    <= '0;
            rec_rst_q <= 1'b1;
            lock_q    <= 1'b0;
            los_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            acq_q     <= acq_d;
            zrun_q    <= zrun_d;
            wdog_q    <= wdog_d;
            cerr_q    <= cerr_d;
            rec_rst_q <= (state_d == ST_RESET_REC);
            lock_q    <= (state_d == ST_LOCKED);
            los_q     <= (state_d == ST_LOS);
        end
    end

    // enable drops on the leaving edge so ais clears with lock
    assign ais_en = (state_q == ST_LOCKED) && (state_d == ST_LOCKED);

    e1_rx_ais_detect #(
        .AIS_WINDOW    (AIS_WINDOW),
        .AIS_MAX_ZEROS (AIS_MAX_ZEROS)
    ) u_ais (
        .clk       (clk),
        .rst       (rst),
        .en_i      (ais_en),
        .bit_stb_i (bus.bit_stb),
        .zero_i    (zero),
        .ais_o     (bus.ais)
    );

    assign bus.rec_rst  = rec_rst_q;
    assign bus.lock     = lock_q;
    assign bus.los      = los_q;
    assign bus.state    = state_q;
    assign bus.cerr_cnt = cerr_q;

endmodule

// File: tb/tb_e1_rx_recovery_ctrl.sv
// Bench for e1_rx_recovery_ctrl: directed scenarios plus random
// bit streams, checked every cycle against a behavioural model.
module tb_e1_rx_recovery_ctrl;

    localparam int RSTC = 4;
    localparam int ACQ  = 16;
    localparam int LOSZ = 32;
    localparam int WIN  = 512;
    localparam int MAXZ = 2;
    localparam int WDOG = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    e1_rx_recovery_ctrl_if bus ();

    e1_rx_recovery_ctrl #(
        .RST_CYCLES    (RSTC),
        .ACQ_PULSES    (ACQ),
        .LOS_ZEROS     (LOSZ),
        .AIS_WINDOW    (WIN),
        .AIS_MAX_ZEROS (MAXZ),
        .WDOG_CYCLES   (WDOG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // model: phase 0 rec-reset, 1 acquire, 2 locked, 3 los
    int m_ph, m_age, m_run, m_marks, m_idle;
    int m_bits, m_wz, m_cerr;
    bit m_ais;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input bit r, input bit p, input bit h,
                         input bit l, input bit s, input bit c);
        bit mk, zr, ce;
        int nxt;
        mk = s && (h || l);
        zr = s && !h && !l;
        ce = s && h && l;
        if (r) begin
            m_ph = 0; m_age = 0; m_run = 0; m_marks = 0;
            m_idle = 0; m_bits = 0; m_wz = 0; m_ais = 0;
            m_cerr = 0;
            return;
        end
        if (c) m_cerr = 0;
        else if (ce && m_ph != 0 && m_cerr < 65535) m_cerr++;
        nxt = m_ph;
        if (m_ph == 0) begin
            m_age++;
            if (m_age == RSTC) nxt = 1;
        end else if (m_ph == 1 || m_ph == 2) begin
            if (mk) m_run = 0;
            else if (zr && m_run < 255) m_run++;
            if (m_ph == 1) begin
                if (mk) m_marks++;
                if (m_run >= LOSZ) nxt = 3;
                else if (mk && m_marks == ACQ) nxt = 2;
            end else begin
                m_idle = s ? 0 : m_idle + 1;
                if (s) begin
                    m_bits++;
                    if (zr) m_wz++;
                    if (m_bits == WIN) begin
                        m_ais = (m_wz <= MAXZ);
                        m_bits = 0;
                        m_wz = 0;
                    end
                end
                if (m_run >= LOSZ) nxt = 3;
                else if (m_idle >= WDOG) nxt = 0;
            end
        end else if (p) begin
            nxt = 0;
        end
        if (nxt != m_ph) begin
            m_age = 0; m_run = 0; m_marks = 0; m_idle = 0;
            m_bits = 0; m_wz = 0; m_ais = 0;
        end
        m_ph = nxt;
    endtask

    task automatic tick(input bit p, input bit h, input bit l,
                        input bit s, input bit c);
        logic [21:0] got_o, exp_o;
        bus.pls_stb  = p;
        bus.bit_hi   = h;
        bus.bit_lo   = l;
        bus.bit_stb  = s;
        bus.cerr_clr = c;
        @(posedge clk);
        model(rst, p, h, l, s, c);
        #1;
        got_o = {bus.rec_rst, bus.lock, bus.los, bus.ais,
                 bus.state, bus.cerr_cnt};
        exp_o = {m_ph == 0, m_ph == 2, m_ph == 3, m_ais,
                 2'(m_ph), 16'(m_cerr)};
        chk("outs", 32'(got_o), 32'(exp_o));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
    endtask

    task automatic mark_bit();
        bit h;
        h = 1'($urandom_range(0, 1));
        tick(0, h, !h, 1, 0);
    endtask

    task automatic zero_bit();
        tick(0, 0, 0, 1, 0);
    endtask

    task automatic rec_rst_len(input string tag);
        int n, g;
        n = bus.rec_rst ? 1 : 0;
        g = 0;
        while (bus.rec_rst && g < 20) begin
            idle(1);
            if (bus.rec_rst) n++;
            g++;
        end
        chk(tag, n, RSTC);
    endtask

    task automatic window(input int nz, input bit lastz,
                          input bit prev, input bit exp_ais);
        bit zp [WIN];
        int k, pos;
        foreach (zp[i]) zp[i] = 0;
        k = 0;
        if (lastz) begin
            zp[WIN-1] = 1;
            k = 1;
        end
        while (k < nz) begin
            pos = $urandom_range(0, WIN - 2);
            if (!zp[pos]) begin
                zp[pos] = 1;
                k++;
            end
        end
        for (int i = 0; i < WIN; i++) begin
            if (i == WIN / 2) chk("ais_mid", bus.ais, prev);
            if (i == WIN - 1) chk("ais_pre_end", bus.ais, prev);
            if (zp[i]) zero_bit();
            else mark_bit();
        end
        chk("ais_end", bus.ais, exp_ais);
    endtask

    initial begin
        bit s, h, l, p, c;
        int sp, zp, ep, pp;
        bus.pls_stb  = 0;
        bus.bit_hi   = 0;
        bus.bit_lo   = 0;
        bus.bit_stb  = 0;
        bus.cerr_clr = 0;

        rst = 1;
        idle(3);
        chk("rst_state", bus.state, 0);
        chk("rst_rec_rst", bus.rec_rst, 1);
        chk("rst_lock_los_ais", {bus.lock, bus.los, bus.ais}, 0);
        chk("rst_cerr", bus.cerr_cnt, 0);
        rst = 0;

        rec_rst_len("t1_rec_rst_len");
        idle(20);
        chk("t1_state", bus.state, 1);
        chk("t1_lock_los", {bus.lock, bus.los}, 0);

        // marks and zeros alternating, one bit every 14 cycles
        for (int i = 1; i <= ACQ; i++) begin
            mark_bit();
            if (i == ACQ - 1) chk("t2_no_lock_15", bus.lock, 0);
            if (i == ACQ) begin
                chk("t2_lock", bus.lock, 1);
                chk("t2_state", bus.state, 2);
            end
            idle(13);
            if (i < ACQ) begin
                zero_bit();
                idle(13);
            end
        end
        for (int i = 0; i < WIN; i++) begin
            if (i % 2 == 0) zero_bit();
            else mark_bit();
            idle(1);
        end
        chk("t2_ais", bus.ais, 0);

        for (int i = 1; i <= LOSZ; i++) begin
            zero_bit();
            if (i == LOSZ - 1) chk("t3_pre_los", {bus.lock, bus.los}, 2'b10);
            if (i == LOSZ) chk("t3_los", {bus.lock, bus.los}, 2'b01);
            idle(1);
        end
        chk("t3_state", bus.state, 3);
        mark_bit();
        idle(3);
        chk("t3_los_hold", bus.state, 3);
        tick(1, 1, 0, 1, 0);
        chk("t3_exit", bus.state, 0);
        rec_rst_len("t3_rec_rst_len");
        chk("t3_acq", bus.state, 1);

        for (int i = 0; i < ACQ; i++) mark_bit();
        chk("t4_lock", bus.lock, 1);
        window(MAXZ, 0, 0, 1);
        window(MAXZ + 1, 0, 1, 0);
        window(MAXZ, 1, 0, 1);
        window(MAXZ + 1, 1, 1, 0);
        window(MAXZ, 0, 0, 1);

        idle(WDOG - 1);
        chk("t5_still_locked", bus.state, 2);
        chk("t5_ais_held", bus.ais, 1);
        idle(1);
        chk("t5_wdog_state", bus.state, 0);
        chk("t5_wdog_rr_ais", {bus.rec_rst, bus.ais}, 2'b10);
        tick(0, 1, 1, 1, 0);
        tick(0, 1, 1, 1, 0);
        chk("t5_cerr_in_rec", bus.cerr_cnt, 0);
        idle(4);
        chk("t5_acq", bus.state, 1);

        for (int i = 0; i < 3; i++) tick(0, 1, 1, 1, 0);
        chk("t6_cerr3", bus.cerr_cnt, 3);
        tick(0, 1, 1, 1, 1);
        chk("t6_clr_wins", bus.cerr_cnt, 0);
        for (int i = 0; i < 65535; i++) tick(0, 1, 1, 1, 0);
        chk("t6_sat", bus.cerr_cnt, 16'hFFFF);
        tick(0, 1, 1, 1, 0);
        chk("t6_sat_hold", bus.cerr_cnt, 16'hFFFF);
        tick(0, 0, 0, 0, 1);
        chk("t6_clr", bus.cerr_cnt, 0);

        for (int i = 0; i < 100; i++) mark_bit();
        tick(0, 1, 1, 1, 0);
        rst = 1;
        idle(1);
        rst = 0;
        chk("rst_mid_state", bus.state, 0);
        chk("rst_mid_rr_ais", {bus.rec_rst, bus.ais}, 2'b10);
        chk("rst_mid_cerr", bus.cerr_cnt, 0);

        for (int seg = 0; seg < 10; seg++) begin
            sp = $urandom_range(5, 100);
            zp = $urandom_range(0, 100);
            ep = $urandom_range(0, 15);
            pp = $urandom_range(0, 20);
            for (int i = 0; i < 200; i++) begin
                s = ($urandom_range(0, 99) < sp);
                if ($urandom_range(0, 99) < zp) {h, l} = 2'b00;
                else if ($urandom_range(0, 99) < ep) {h, l} = 2'b11;
                else if ($urandom_range(0, 1) == 1) {h, l} = 2'b10;
                else {h, l} = 2'b01;
                p = ($urandom_range(0, 99) < pp);
                c = ($urandom_range(0, 99) < 2);
                rst = ($urandom_range(0, 999) == 0);
                tick(p, h, l, s, c);
            end
        end
        rst = 0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/e1_rx_recovery_ctrl.md
Name: e1_rx_recovery_ctrl

Overview:
Supervisory controller for the E1 receive clock-recovery stage. It holds the recovery counter in reset, sequences acquisition, and declares lock. It monitors the recovered bit stream for loss of signal (LOS), AIS (all-ones) and bipolar code errors. It sits between the LIU pulse sampler / clock-recovery pair and the HDB3 decoder / framer, and drives the recovery stage's `rst`.

Parameters:
RST_CYCLES, 4, number of cycles `rec_rst` is held high on each re-acquisition (1..15).
ACQ_PULSES, 16, marks (non-zero recovered bits) required in ACQUIRE before declaring lock (1..255).
LOS_ZEROS, 32, consecutive recovered zeros that declare LOS (1..255).
AIS_WINDOW, 512, recovered bits per AIS evaluation window (power of two, 16..4096).
AIS_MAX_ZEROS, 2, AIS is declared when a window contains at most this many zeros.
WDOG_CYCLES, 64, clk cycles with no `bit_stb` in LOCKED before forcing re-acquisition (≤255).

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
pls_stb  in  1  raw pulse-edge strobe from the LIU sampler (same signal feeding the recovery `in_stb`).
bit_hi  in  1  recovered positive mark, valid with `bit_stb`.
bit_lo  in  1  recovered negative mark, valid with `bit_stb`.
bit_stb  in  1  recovered bit strobe (clock-recovery `out_stb`).
rec_rst  out  1  reset to the clock-recovery instance.
lock  out  1  state == LOCKED.
los  out  1  state == LOS.
ais  out  1  AIS indication (LOCKED only).
state  out  2  current state encoding.
cerr_cnt  out  16  saturating count of code errors (`bit_hi` & `bit_lo` together at `bit_stb`).
cerr_clr  in  1  clears `cerr_cnt` (wins over a simultaneous increment).

Behaviour:
- Clock `clk`; reset `rst` is synchronous, active-high. All outputs are registered.
- Reset values:
  - state = RESET_REC (2'd0), with `rec_rst`=1.
  - `lock`=0, `los`=0, `ais`=0, `cerr_cnt`=0.
  - All internal counters = 0.
- Mark = `bit_stb` & (`bit_hi` | `bit_lo`). Zero = `bit_stb` & !`bit_hi` & !`bit_lo`.
- zrun: 8-bit counter of consecutive zeros.
  - Any mark resets it to 0.
  - Saturates at 255.
  - Cleared on every state change.
- States:
  - RESET_REC (0):
    - `rec_rst`=1; a cycle counter counts to RST_CYCLES-1.
    - Then → ACQUIRE. `rec_rst` is high for exactly RST_CYCLES cycles.
    - Inputs are ignored.
  - ACQUIRE (1):
    - Mark increments an 8-bit acq counter.
    - When the counter reaches ACQ_PULSES on a mark → LOCKED, next cycle.
    - When a zero makes zrun reach LOS_ZEROS → LOS. LOS wins if both conditions occur on the same strobe, which is impossible by construction.
  - LOCKED (2):
    - zrun reaching LOS_ZEROS → LOS.
    - The watchdog counter resets on each `bit_stb`. Reaching WDOG_CYCLES → RESET_REC.
    - If LOS and the watchdog trigger in the same cycle, LOS wins.
  - LOS (3):
    - The first `pls_stb` → RESET_REC.
    - `bit_stb` is ignored. `pls_stb` and `bit_stb` in the same cycle still exit.
- Output timing: `lock`/`los` assert on the cycle the registered state changes, i.e. 1 cycle after the triggering strobe.
- AIS:
  - Active only in LOCKED.
  - The window counter counts `bit_stb`. The zero counter saturates at AIS_MAX_ZEROS+1.
  - On the last bit of a window: `ais` <= (zeros ≤ AIS_MAX_ZEROS), then both counters clear. The last bit itself is included.
  - Leaving LOCKED clears `ais` and both counters immediately.
- Code errors:
  - Counted in all states except RESET_REC.
  - `cerr_cnt` saturates at 0xFFFF.
  - A code-error bit counts as a mark for zrun/acq purposes.
- Reset mid-operation: `rst` on any cycle forces the reset values on the next edge, including mid-window and mid-RESET_REC.

Decomposition:
- Package e1_pkg (shared): state encoding constants ST_RESET_REC/ST_ACQUIRE/ST_LOCKED/ST_LOS and the default LOS/AIS thresholds.
- One sub-module: e1_rx_ais_detect, containing the window counter, the zero counter and the `ais` register, with inputs `bit_stb`, zero, enable=LOCKED.

Test Plan:
1. Reset release: `rec_rst` high exactly 4 cycles. Then with no input, state stays 1; `lock`/`los` = 0.
2. Alternating mark/zero bits every 14 cycles: the 16th mark → `lock`=1, state=2 one cycle later. `ais`=0 after 512 bits (256 zeros).
3. Locked, then 32 consecutive zeros: `los`=1, `lock`=0 one cycle after the 32nd zero. Then one `pls_stb` → `rec_rst` high 4 cycles → ACQUIRE.
4. Locked, all-marks for 512 bits with exactly 2 zeros: `ais`=1 at window end. Next window with 3 zeros: `ais`=0.
5. Locked, `bit_stb` stopped: after 64 cycles → RESET_REC, `rec_rst`=1.
6. Three `bit_hi`&`bit_lo` strobes → `cerr_cnt`=3. `cerr_clr` coincident with a 4th error → 0. Saturation check: 0xFFFF stays 0xFFFF.
